uart_sample_receiver: RTL and testbench

//  Receive end of the UART sample link. Deserialises 8N1 bytes from UART_RX
//  and reassembles 3-byte packets into 22-bit vibration samples plus a
//  new-frame flag. Presents each sample on a valid/ready handshake to the

---
 rtl/uart_sample_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_uart_sample_receiver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_receiver.sv
// uart_sample_receiver: UART receive end of the sample link.
// Deserialises UART_RX bytes and reassembles 3-byte packets into a
// 22-bit sample plus new-frame flag, presented on a valid/ready handshake.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing (default 8N1).
module uart_sample_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        UART_RX,
  output logic [21:0] o_data,
  output logic        o_new_frame,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_frame_err,
  output logic        o_sync_err,
  output logic        o_overrun
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W     = $clog2(TMO_LIMIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t             r_state, w_next_state;
  logic               r_rx_meta, r_rx_sync;
  logic [CNT_W-1:0]   r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [1:0]         r_byte_idx;
  logic [6:0]         r_hdr;
  logic [7:0]         r_mid;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [21:0]        r_data;
  logic               r_new_frame, r_valid, r_frame_err, r_sync_err, r_overrun;

  logic w_bit_tick, w_half_tick, w_stop_smp, w_byte_ok, w_stop_err;
  logic w_par_err, w_hdr_err, w_tmo, w_pkt_done;

  assign w_bit_tick  = (r_clk_cnt == BIT_LAST);
  assign w_half_tick = (r_clk_cnt == HALF_LAST);
  assign w_stop_smp  = (r_state == S_STOP) && w_bit_tick;
  assign w_stop_err  = w_stop_smp && !r_rx_sync;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_err = (r_state == S_PARITY) && w_bit_tick && (r_rx_sync != ^r_shift);
  assign w_byte_ok = w_stop_smp && r_rx_sync && !r_par_bad;
`else
  assign w_par_err = 1'b0;
  assign w_byte_ok = w_stop_smp && r_rx_sync;
`endif

  assign w_hdr_err  = w_byte_ok && (r_byte_idx == 2'd0) && !r_shift[7];
  assign w_tmo      = (r_byte_idx != 2'd0) && !w_byte_ok && (r_tmo_cnt == TMO_LAST);
  assign w_pkt_done = w_byte_ok && (r_byte_idx == 2'd2);

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Bit FSM state register.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Bit FSM next state; IDLE starts on a low level, which after the sync
  // chain is the falling edge since every path back to IDLE sees the line high.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_sync) w_next_state = S_START;
      S_START: if (w_half_tick) w_next_state = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:
        if (w_bit_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_bit_tick) w_next_state = S_STOP;
`endif
      S_STOP:  if (w_bit_tick) w_next_state = r_rx_sync ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_sync) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bit timing counter, data shift register and parity check.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) || (r_state == S_BREAK)) r_clk_cnt <= '0;
      else if ((r_state == S_START) && w_half_tick)     r_clk_cnt <= '0;
      else if (w_bit_tick)                              r_clk_cnt <= '0;
      else                                              r_clk_cnt <= r_clk_cnt + CNT_W'(1);

      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == S_DATA) && w_bit_tick) begin
        r_shift   <= {r_rx_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if ((r_state == S_PARITY) && w_bit_tick) r_par_bad <= w_par_err;
`endif
    end
  end

  // Packet assembly, byte index and inter-byte timeout.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_idx <= '0;
      r_hdr      <= '0;
      r_mid      <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      if ((r_byte_idx == 2'd0) || w_byte_ok) r_tmo_cnt <= '0;
      else                                   r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (w_stop_err || w_par_err || w_tmo) begin
        r_byte_idx <= '0;
      end else if (w_byte_ok) begin
        case (r_byte_idx)
          2'd0: if (r_shift[7]) begin
                  r_hdr      <= r_shift[6:0];
                  r_byte_idx <= 2'd1;
                end
          2'd1: begin
                  r_mid      <= r_shift;
                  r_byte_idx <= 2'd2;
                end
          default: r_byte_idx <= 2'd0;
        endcase
      end
    end
  end

  // Output sample register, handshake and one-cycle error pulses.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_new_frame <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_frame_err <= w_stop_err || w_par_err;
      r_sync_err  <= w_hdr_err || w_tmo;
      if (w_pkt_done) begin
        r_data      <= {r_hdr[5:0], r_mid, r_shift};
        r_new_frame <= r_hdr[6];
        r_valid     <= 1'b1;
        r_overrun   <= r_valid && !i_ready;
      end else begin
        r_overrun <= 1'b0;
        if (r_valid && i_ready) r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_new_frame = r_new_frame;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_sync_err  = r_sync_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_sample_receiver.sv
// Directed bench for uart_sample_receiver with a short bit period.
module tb_uart_sample_receiver;

  localparam int unsigned CPB = 16;
  localparam int unsigned TOB = 20;

  logic        sys_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        UART_RX   = 1'b1;
  logic        i_ready   = 1'b0;
  logic [21:0] o_data;
  logic        o_new_frame, o_valid, o_frame_err, o_sync_err, o_overrun;

  uart_sample_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .UART_RX    (UART_RX),
    .o_data     (o_data),
    .o_new_frame(o_new_frame),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_sync_err (o_sync_err),
    .o_overrun  (o_overrun)
  );

  always #5 sys_clock = ~sys_clock;

  int n_cmp = 0, n_fail = 0;
  int n_frame = 0, n_sync = 0, n_ovr = 0;
  int cyc = 0, last_sync_cyc = 0;
  logic p_frame = 1'b0, p_sync = 1'b0, p_ovr = 1'b0;
  logic [22:0] acc_q[$];
`ifdef UART_RX_PARITY_EN
  bit tb_par_flip = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge: pulse counting, pulse width, accepted samples.
  always @(negedge sys_clock) begin
    cyc++;
    if (reset_n) begin
      if (o_frame_err) begin n_frame++; check("frame_err width", 32'(p_frame), 32'd0); end
      if (o_sync_err)  begin n_sync++;  last_sync_cyc = cyc; check("sync_err width", 32'(p_sync), 32'd0); end
      if (o_overrun)   begin n_ovr++;   check("overrun width", 32'(p_ovr), 32'd0); end
      if (o_valid && i_ready) acc_q.push_back({o_new_frame, o_data});
    end
    p_frame = o_frame_err;
    p_sync  = o_sync_err;
    p_ovr   = o_overrun;
  end

  task automatic clear_mon();
    n_frame = 0; n_sync = 0; n_ovr = 0;
    acc_q.delete();
  endtask

  task automatic drive_bit(input logic v);
    UART_RX = v;
    repeat (CPB) @(posedge sys_clock);
    #1;
  endtask

  task automatic idle_bits(input int n);
    UART_RX = 1'b1;
    repeat (n * CPB) @(posedge sys_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ tb_par_flip);
`endif
    drive_bit(stop_v);
    UART_RX = 1'b1;
  endtask

  task automatic send_pkt(input logic [23:0] p);
    send_byte(p[23:16], 1'b1);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  typedef struct {
    int          nb;
    logic [23:0] bytes;
    int          bad_stop;
    logic [21:0] exp_data;
    logic        exp_nf;
    int          exp_acc;
    int          exp_fe;
    int          exp_se;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0]  b0, b1, b2;
    logic [22:0] exp_q[$];
    logic [23:0] v;
    int          t_end;

    vecs[0] = '{3, 24'hBCF0F0, -1, 22'h3CF0F0, 1'b0, 1, 0, 0};
    vecs[1] = '{3, 24'hFF1234, -1, 22'h3F1234, 1'b1, 1, 0, 0};
    vecs[2] = '{3, 24'h800000, -1, 22'h000000, 1'b0, 1, 0, 0};
    vecs[3] = '{1, 24'h3C0000, -1, 22'h000000, 1'b0, 0, 0, 1};
    vecs[4] = '{3, 24'hC1A55A, -1, 22'h01A55A, 1'b1, 1, 0, 0};
    vecs[5] = '{2, 24'hBCF000,  1, 22'h000000, 1'b0, 0, 1, 0};
    vecs[6] = '{3, 24'h9F00FF, -1, 22'h1F00FF, 1'b0, 1, 0, 0};

    // Reset state
    @(posedge sys_clock); #1;
    repeat (3) @(posedge sys_clock);
    #1;
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_data", 32'(o_data), 32'd0);
    check("reset o_new_frame", 32'(o_new_frame), 32'd0);
    check("reset err pulses", 32'({o_frame_err, o_sync_err, o_overrun}), 32'd0);
    reset_n = 1'b1;
    idle_bits(2);

    // Table-driven packets
    i_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      v = vecs[i].bytes;
      for (int j = 0; j < vecs[i].nb; j++)
        send_byte(v[23-8*j -: 8], (j == vecs[i].bad_stop) ? 1'b0 : 1'b1);
      idle_bits(2);
      check($sformatf("vec%0d accepted", i), 32'(acc_q.size()), 32'(vecs[i].exp_acc));
      if (vecs[i].exp_acc > 0 && acc_q.size() > 0)
        check($sformatf("vec%0d sample", i), 32'(acc_q[0]), 32'({vecs[i].exp_nf, vecs[i].exp_data}));
      check($sformatf("vec%0d frame_err", i), 32'(n_frame), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d sync_err", i), 32'(n_sync), 32'(vecs[i].exp_se));
      check($sformatf("vec%0d overrun", i), 32'(n_ovr), 32'd0);
    end

    // 16 back-to-back packets, consumer always ready
    clear_mon();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      b0 = {1'b1, 1'(k), 6'(k * 5)};
      b1 = 8'(k * 17);
      b2 = 8'(255 - k * 3);
      exp_q.push_back({b0[6:0], b1, b2});
      send_pkt({b0, b1, b2});
    end
    idle_bits(2);
    check("b2b count", 32'(acc_q.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      if (k < acc_q.size()) check($sformatf("b2b sample%0d", k), 32'(acc_q[k]), 32'(exp_q[k]));
    check("b2b overrun", 32'(n_ovr), 32'd0);
    check("b2b errors", 32'(n_frame + n_sync), 32'd0);

    // Overrun: second sample overwrites an unaccepted one
    clear_mon();
    i_ready = 1'b0;
    send_pkt(24'hC01122);
    idle_bits(1);
    check("ovr first valid", 32'(o_valid), 32'd1);
    check("ovr first data", 32'(o_data), 32'h001122);
    check("ovr first nf", 32'(o_new_frame), 32'd1);
    send_pkt(24'h856677);
    idle_bits(1);
    check("ovr pulse count", 32'(n_ovr), 32'd1);
    check("ovr valid held", 32'(o_valid), 32'd1);
    check("ovr data", 32'(o_data), 32'h056677);
    check("ovr nf", 32'(o_new_frame), 32'd0);
    i_ready = 1'b1;
    @(posedge sys_clock); #1;
    check("ovr valid drop", 32'(o_valid), 32'd0);
    check("ovr accepted count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("ovr accepted data", 32'(acc_q[0]), 32'h056677);

    // Inter-byte timeout after two bytes of a packet
    clear_mon();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    t_end = cyc;
    idle_bits(25);
    check("tmo sync count", 32'(n_sync), 32'd1);
    check("tmo no valid", 32'(acc_q.size()), 32'd0);
    check("tmo timing window", 32'((last_sync_cyc - t_end >= 305) && (last_sync_cyc - t_end <= 325)), 32'd1);
    clear_mon();
    send_pkt(24'hBCF0F0);
    idle_bits(2);
    check("tmo recovery count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("tmo recovery data", 32'(acc_q[0]), 32'h3CF0F0);

    // Short low glitch on the idle line
    clear_mon();
    UART_RX = 1'b0;
    repeat (5) @(posedge sys_clock);
    #1;
    idle_bits(3);
    check("glitch errors", 32'(n_frame + n_sync), 32'd0);
    check("glitch no valid", 32'(acc_q.size()), 32'd0);
    send_pkt(24'hFF1234);
    idle_bits(2);
    check("glitch recovery count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("glitch recovery data", 32'(acc_q[0]), 32'h7F1234);

    // Reset in the middle of byte1, with a pending sample held
    i_ready = 1'b0;
    send_pkt(24'h9F00FF);
    idle_bits(1);
    check("pre-reset valid", 32'(o_valid), 32'd1);
    send_byte(8'hBC, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    reset_n = 1'b0;
    UART_RX = 1'b1;
    clear_mon();
    repeat (3) @(posedge sys_clock);
    #1;
    check("mid reset o_valid", 32'(o_valid), 32'd0);
    check("mid reset o_data", 32'(o_data), 32'd0);
    check("mid reset o_new_frame", 32'(o_new_frame), 32'd0);
    reset_n = 1'b1;
    idle_bits(3);
    check("post reset pulses", 32'(n_frame + n_sync + n_ovr), 32'd0);
    i_ready = 1'b1;
    send_pkt(24'hC1A55A);
    idle_bits(2);
    check("post reset count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("post reset data", 32'(acc_q[0]), 32'h41A55A);

`ifdef UART_RX_PARITY_EN
    // Wrong parity on byte1 drops the packet
    clear_mon();
    send_byte(8'hBC, 1'b1);
    tb_par_flip = 1'b1;
    send_byte(8'hF0, 1'b1);
    tb_par_flip = 1'b0;
    idle_bits(2);
    check("parity frame_err", 32'(n_frame), 32'd1);
    check("parity no valid", 32'(acc_q.size()), 32'd0);
    send_pkt(24'hBCF0F0);
    idle_bits(2);
    check("parity recovery count", 32'(acc_q.size()), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
